// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches 16-bit instruction words as two byte reads (lo at PC, hi at PC+1)
// and hands each word downstream over a valid/ready handshake.
module instr_fetch_unit #(
   parameter logic [15:0] START_ADDR = 16'h0000,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Enable,
   input  logic        PCLoad,
   input  logic [15:0] PCIn,
   output logic        MemReq,
   output logic [15:0] MemAddr,
   input  logic [7:0]  MemData,
   input  logic        MemAck,
   output logic [15:0] IRWord,
   output logic        IRValid,
   input  logic        IRReady,
   output logic [15:0] PC,
   output logic        Timeout
);
   typedef enum logic [1:0] {IDLE, REQ_LO, REQ_HI, HOLD} state_t;
   state_t state, state_nxt;
   logic [7:0] wait_cnt;
   logic in_req, xfer, expire;
   assign in_req  = (state == REQ_LO) || (state == REQ_HI);
   assign MemReq  = in_req;
   assign MemAddr = PC;
   assign xfer    = in_req && MemAck;
   // an ack arriving on the last allowed wait cycle still completes the transfer
   assign expire  = in_req && !MemAck && (wait_cnt == 8'(TIMEOUT - 1));
   always_comb begin
      state_nxt = state;
      if (PCLoad)
         state_nxt = IDLE;
      else
         case (state)
            IDLE:    state_nxt = Enable ? REQ_LO : IDLE;
            REQ_LO:  state_nxt = MemAck ? REQ_HI : (expire ? IDLE : REQ_LO);
            REQ_HI:  state_nxt = MemAck ? HOLD : (expire ? IDLE : REQ_HI);
            HOLD:    state_nxt = IRReady ? (Enable ? REQ_LO : IDLE) : HOLD;
            default: state_nxt = IDLE;
         endcase
   end
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state    <= IDLE;
         PC       <= START_ADDR;
         IRWord   <= 16'h0000;
         IRValid  <= 1'b0;
         Timeout  <= 1'b0;
         wait_cnt <= 8'd0;
      end else begin
         state <= state_nxt;
         if (PCLoad) begin
            PC       <= PCIn;
            IRValid  <= 1'b0;
            wait_cnt <= 8'd0;
         end else begin
            if (xfer)
               PC <= PC + 16'd1;
            if (xfer && state == REQ_LO)
               IRWord[7:0] <= MemData;
            if (xfer && state == REQ_HI) begin
               IRWord[15:8] <= MemData;
               IRValid      <= 1'b1;
            end
            if (state == HOLD && IRReady)
               IRValid <= 1'b0;
            if (expire)
               Timeout <= 1'b1;
            wait_cnt <= (in_req && !MemAck && !expire) ? wait_cnt + 8'd1 : 8'd0;
         end
      end
   end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed stimulus against a byte memory, with a transaction-level
// reference model compared every cycle plus hand-computed spot checks.
module tb_instr_fetch_unit;
   localparam int TO = 15;
   logic        Clock = 1'b0, Reset = 1'b0, Enable = 1'b0, PCLoad = 1'b0, MemAck = 1'b0, IRReady = 1'b0;
   logic [15:0] PCIn = 16'h0000;
   logic        MemReq, IRValid, Timeout;
   logic [15:0] MemAddr, IRWord, PC;
   logic [7:0]  MemData;
   logic [7:0]  mem [0:65535];
   int errs = 0, checks = 0;
   bit done = 1'b0;
   // model: busy = requesting bytes, hi = low byte already taken, valid = word waiting downstream
   bit m_busy = 1'b0, m_hi = 1'b0, m_valid = 1'b0, m_to = 1'b0;
   int m_wait = 0;
   logic [15:0] m_pc = 16'h0000, m_word = 16'h0000;

   instr_fetch_unit #(.START_ADDR(16'h0000), .TIMEOUT(TO)) dut (
      .Clock(Clock), .Reset(Reset), .Enable(Enable), .PCLoad(PCLoad), .PCIn(PCIn),
      .MemReq(MemReq), .MemAddr(MemAddr), .MemData(MemData), .MemAck(MemAck),
      .IRWord(IRWord), .IRValid(IRValid), .IRReady(IRReady), .PC(PC), .Timeout(Timeout)
   );

   always #5 Clock = ~Clock;
   assign MemData = mem[MemAddr];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      #2;
   endtask

   initial forever begin
      @(posedge Clock or negedge Reset);
      if (!Reset) begin
         m_busy = 1'b0; m_hi = 1'b0; m_valid = 1'b0; m_to = 1'b0; m_wait = 0;
         m_pc = 16'h0000; m_word = 16'h0000;
      end else if (PCLoad) begin
         m_pc = PCIn; m_busy = 1'b0; m_hi = 1'b0; m_valid = 1'b0; m_wait = 0;
      end else if (m_valid) begin
         if (IRReady) begin
            m_valid = 1'b0;
            m_busy  = Enable;
         end
      end else if (!m_busy) begin
         m_busy = Enable;
      end else if (MemAck) begin
         if (m_hi) m_word[15:8] = mem[m_pc];
         else      m_word[7:0]  = mem[m_pc];
         m_pc   = m_pc + 16'd1;
         m_wait = 0;
         if (m_hi) begin
            m_busy  = 1'b0;
            m_valid = 1'b1;
         end
         m_hi = !m_hi;
      end else begin
         m_wait++;
         if (m_wait == TO) begin
            m_to = 1'b1; m_busy = 1'b0; m_hi = 1'b0; m_wait = 0;
         end
      end
   end

   initial forever begin
      @(negedge Clock);
      if (!done && Reset) begin
         chk("cyc_memreq", 16'(MemReq), 16'(m_busy));
         chk("cyc_memaddr", MemAddr, m_pc);
         chk("cyc_pc", PC, m_pc);
         chk("cyc_irvalid", 16'(IRValid), 16'(m_valid));
         chk("cyc_irword", IRWord, m_word);
         chk("cyc_timeout", 16'(Timeout), 16'(m_to));
      end
   end

   initial begin
      int n;
      for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 37 + 11);
      mem[16'h0000] = 8'h34; mem[16'h0001] = 8'h12;
      mem[16'h0002] = 8'h78; mem[16'h0003] = 8'h56;
      mem[16'hFFFF] = 8'hCD;
      mem[16'h4000] = 8'h5A; mem[16'h4001] = 8'hA5;
      #12;
      chk("rst_pc", PC, 16'h0000);
      chk("rst_memreq", 16'(MemReq), 16'h0000);
      chk("rst_irvalid", 16'(IRValid), 16'h0000);
      chk("rst_timeout", 16'(Timeout), 16'h0000);
      chk("rst_irword", IRWord, 16'h0000);
      Reset = 1'b1; Enable = 1'b1; MemAck = 1'b1; IRReady = 1'b1;
      step();
      chk("f1_req_lo", 16'(MemReq), 16'h0001);
      chk("f1_addr", MemAddr, 16'h0000);
      step();
      chk("f1_pc1", PC, 16'h0001);
      step();
      chk("f1_valid", 16'(IRValid), 16'h0001);
      chk("f1_word", IRWord, 16'h1234);
      chk("f1_pc2", PC, 16'h0002);
      IRReady = 1'b0;
      repeat (5) begin
         step();
         chk("hold_valid", 16'(IRValid), 16'h0001);
         chk("hold_word", IRWord, 16'h1234);
         chk("hold_memreq", 16'(MemReq), 16'h0000);
         chk("hold_pc", PC, 16'h0002);
      end
      IRReady = 1'b1;
      step();
      chk("acc_valid", 16'(IRValid), 16'h0000);
      chk("acc_memreq", 16'(MemReq), 16'h0001);
      chk("acc_addr", MemAddr, 16'h0002);
      step();
      chk("abort_lo", IRWord, 16'h1278);
      PCLoad = 1'b1; PCIn = 16'h8000;
      step();
      PCLoad = 1'b0;
      chk("abort_pc", PC, 16'h8000);
      chk("abort_idle", 16'(MemReq), 16'h0000);
      chk("abort_nocap", IRWord, 16'h1278);
      chk("abort_valid", 16'(IRValid), 16'h0000);
      step();
      chk("resume_req", 16'(MemReq), 16'h0001);
      chk("resume_addr", MemAddr, 16'h8000);
      repeat (3) step();
      PCLoad = 1'b1; PCIn = 16'hFFFF; mem[16'h0000] = 8'hAB;
      step();
      PCLoad = 1'b0;
      n = 0;
      while (!IRValid && n < 20) begin
         step();
         n++;
      end
      chk("wrap_valid", 16'(IRValid), 16'h0001);
      chk("wrap_word", IRWord, 16'hABCD);
      chk("wrap_pc", PC, 16'h0001);
      MemAck = 1'b0; PCLoad = 1'b1; PCIn = 16'h4000;
      step();
      PCLoad = 1'b0;
      step();
      chk("to_req", 16'(MemReq), 16'h0001);
      chk("to_addr", MemAddr, 16'h4000);
      repeat (14) step();
      chk("late_ack_pre", 16'(Timeout), 16'h0000);
      MemAck = 1'b1;
      step();
      chk("late_ack_to", 16'(Timeout), 16'h0000);
      chk("late_ack_pc", PC, 16'h4001);
      chk("late_ack_lo", 16'(IRWord[7:0]), 16'h005A);
      MemAck = 1'b0;
      repeat (14) step();
      chk("to_pre", 16'(Timeout), 16'h0000);
      chk("to_pre_req", 16'(MemReq), 16'h0001);
      step();
      chk("to_flag", 16'(Timeout), 16'h0001);
      chk("to_idle", 16'(MemReq), 16'h0000);
      chk("to_pc", PC, 16'h4001);
      step();
      chk("refetch_req", 16'(MemReq), 16'h0001);
      chk("refetch_addr", MemAddr, 16'h4001);
      chk("to_sticky", 16'(Timeout), 16'h0001);
      MemAck = 1'b1;
      step();
      chk("req_hi_pc", PC, 16'h4002);
      Reset = 1'b0;
      #1;
      chk("async_memreq", 16'(MemReq), 16'h0000);
      chk("async_valid", 16'(IRValid), 16'h0000);
      chk("async_timeout", 16'(Timeout), 16'h0000);
      chk("async_pc", PC, 16'h0000);
      chk("async_word", IRWord, 16'h0000);
      #1;
      Reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         IRReady = (i % 3) != 0;
         step();
      end
      done = 1'b1;
      step();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
